// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/gnt/rvalid fetch into the IF/ID register, with stall, redirect and kill handling.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit (
  input  logic        clk,
  input  logic        startin,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cyc
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        deliver;
  logic [31:0] deliver_pc;
  logic [31:0] deliver_instr;

  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    req_pc_d      = req_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    deliver       = 1'b0;
    deliver_pc    = req_pc_q;
    deliver_instr = imem_rdata;
    case (state_q)
      S_REQ: begin
        if (!redirect && imem_gnt) begin
          req_pc_d = pc_in;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect racing the response drops it; otherwise the response still owed is marked dead.
        if (redirect) begin
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall) begin
            deliver = 1'b1;
            state_d = S_REQ;
          end else begin
            buf_pc_d    = req_pc_q;
            buf_instr_d = imem_rdata;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_pc    = buf_pc_q;
          deliver_instr = buf_instr_q;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req  = !startin && (state_q == S_REQ) && !redirect;
  assign imem_addr = (!startin && (state_q == S_REQ)) ? pc_in : 32'h0;
  assign pc_write  = !startin && (redirect || deliver);
  assign pc_next   = !pc_write ? 32'h0 : (redirect ? redirect_pc : deliver_pc + 32'd4);

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    if (redirect) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (deliver) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = deliver_pc;
      ifid_pc4_d   = deliver_pc + 32'd4;
      ifid_instr_d = deliver_instr;
    end else if (!stall) begin
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      state_q      <= S_REQ;
      kill_q       <= 1'b0;
      req_pc_q     <= 32'h0;
      buf_pc_q     <= 32'h0;
      buf_instr_q  <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      req_pc_q     <= req_pc_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_instr = ifid_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_cyc_q;

  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      fetched_q   <= 32'h0;
      stall_cyc_q <= 32'h0;
    end else begin
      if (deliver && !redirect) fetched_q <= fetched_q + 32'd1;
      if (stall) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_stall_cyc = stall_cyc_q;
`else
  assign perf_fetched   = 32'h0;
  assign perf_stall_cyc = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: per-cycle vectors plus a scoreboard of delivered instructions.
module tb_fetch_unit;

  logic        clk;
  logic        startin;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cyc;

  fetch_unit dut (
    .clk(clk), .startin(startin), .pc_in(pc_in), .pc_next(pc_next), .pc_write(pc_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr),
    .perf_fetched(perf_fetched), .perf_stall_cyc(perf_stall_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stl;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        pw;
    logic [31:0] pn;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] instr;
    logic        push;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  localparam int NV = 33;
  vec_t vecs[NV];
  sb_t  sbQ[$];

  int checks = 0;
  int errors = 0;
  int unsigned modelFetched = 0;
  int unsigned modelStall = 0;
  logic [31:0] gntPc = 32'h0;
  logic sStall, sRedir, sRst;

  function automatic vec_t mk(
    input logic [31:0] rst, pc, gnt, rv, rdata, stl, redir, rpc,
    input logic [31:0] req, addr, pw, pn, vld, ipc, ipc4, instr, push);
    vec_t v;
    v.rst = rst[0];   v.pc = pc;     v.gnt = gnt[0];   v.rv = rv[0];
    v.rdata = rdata;  v.stl = stl[0]; v.redir = redir[0]; v.rpc = rpc;
    v.req = req[0];   v.addr = addr; v.pw = pw[0];     v.pn = pn;
    v.vld = vld[0];   v.ipc = ipc;   v.ipc4 = ipc4;    v.instr = instr;
    v.push = push[0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    startin     = v.rst;
    pc_in       = v.pc;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    stall       = v.stl;
    redirect    = v.redir;
    redirect_pc = v.rpc;
  endtask

  // Every edge that should load IF/ID must match the oldest word queued when its response was driven.
  always begin
    @(posedge clk);
    sStall = stall;
    sRedir = redirect;
    sRst   = startin;
    #1;
    if (!sRst && !sRedir && !sStall && ifid_valid === 1'b1) begin
      checkOutput("sbNonEmpty", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        sb_t e;
        e = sbQ.pop_front();
        checkOutput("sbPc", ifid_pc, e.pc);
        checkOutput("sbPc4", ifid_pc4, e.pc + 32'd4);
        checkOutput("sbInstr", ifid_instr, e.instr);
      end
    end
  end

  initial begin
    //           rst pc            gnt rv rdata          stl rd rpc       req addr          pw pn        vld ipc           ipc4      instr          push
    vecs[0]  = mk(1, 0,            0, 0, 0,             0, 0, 0,        0, 0,            0, 0,        0, 0,            0,        0,             0);
    vecs[1]  = mk(0, 0,            1, 0, 0,             0, 0, 0,        1, 0,            0, 0,        0, 0,            0,        0,             0);
    vecs[2]  = mk(0, 0,            0, 1, 32'h12345678,  0, 0, 0,        0, 0,            1, 4,        1, 0,            4,        32'h12345678,  1);
    vecs[3]  = mk(0, 4,            1, 0, 0,             0, 0, 0,        1, 4,            0, 0,        0, 0,            4,        32'h12345678,  0);
    vecs[4]  = mk(0, 4,            0, 0, 0,             0, 0, 0,        0, 0,            0, 0,        0, 0,            4,        32'h12345678,  0);
    vecs[5]  = mk(0, 4,            0, 1, 32'hAAAA0004,  0, 0, 0,        0, 0,            1, 8,        1, 4,            8,        32'hAAAA0004,  1);
    vecs[6]  = mk(0, 8,            0, 0, 0,             0, 0, 0,        1, 8,            0, 0,        0, 4,            8,        32'hAAAA0004,  0);
    vecs[7]  = mk(0, 8,            1, 0, 0,             0, 0, 0,        1, 8,            0, 0,        0, 4,            8,        32'hAAAA0004,  0);
    vecs[8]  = mk(0, 8,            0, 1, 32'hBBBB0008,  1, 0, 0,        0, 0,            0, 0,        0, 4,            8,        32'hAAAA0004,  1);
    vecs[9]  = mk(0, 8,            0, 0, 0,             1, 0, 0,        0, 0,            0, 0,        0, 4,            8,        32'hAAAA0004,  0);
    vecs[10] = mk(0, 8,            0, 0, 0,             1, 0, 0,        0, 0,            0, 0,        0, 4,            8,        32'hAAAA0004,  0);
    vecs[11] = mk(0, 8,            0, 0, 0,             0, 0, 0,        0, 0,            1, 32'hC,    1, 8,            32'hC,    32'hBBBB0008,  0);
    vecs[12] = mk(0, 32'hC,        1, 0, 0,             0, 0, 0,        1, 32'hC,        0, 0,        0, 8,            32'hC,    32'hBBBB0008,  0);
    vecs[13] = mk(0, 32'hC,        0, 0, 0,             0, 1, 32'h100,  0, 0,            1, 32'h100,  0, 8,            32'hC,    0,             0);
    vecs[14] = mk(0, 32'h100,      0, 1, 32'hDEADBEEF,  0, 0, 0,        0, 0,            0, 0,        0, 8,            32'hC,    0,             0);
    vecs[15] = mk(0, 32'h100,      1, 0, 0,             0, 0, 0,        1, 32'h100,      0, 0,        0, 8,            32'hC,    0,             0);
    vecs[16] = mk(0, 32'h100,      0, 1, 32'h11110100,  0, 0, 0,        0, 0,            1, 32'h104,  1, 32'h100,      32'h104,  32'h11110100,  1);
    vecs[17] = mk(0, 32'hFFFFFFFC, 1, 0, 0,             0, 0, 0,        1, 32'hFFFFFFFC, 0, 0,        0, 32'h100,      32'h104,  32'h11110100,  0);
    vecs[18] = mk(0, 32'hFFFFFFFC, 0, 1, 32'h2222FFFC,  0, 0, 0,        0, 0,            1, 0,        1, 32'hFFFFFFFC, 0,        32'h2222FFFC,  1);
    vecs[19] = mk(0, 0,            1, 0, 0,             0, 1, 32'h200,  0, 0,            1, 32'h200,  0, 32'hFFFFFFFC, 0,        0,             0);
    vecs[20] = mk(0, 32'h200,      1, 0, 0,             0, 0, 0,        1, 32'h200,      0, 0,        0, 32'hFFFFFFFC, 0,        0,             0);
    vecs[21] = mk(0, 32'h200,      0, 1, 32'h33330200,  1, 0, 0,        0, 0,            0, 0,        0, 32'hFFFFFFFC, 0,        0,             0);
    vecs[22] = mk(0, 32'h200,      0, 0, 0,             1, 1, 32'h300,  0, 0,            1, 32'h300,  0, 32'hFFFFFFFC, 0,        0,             0);
    vecs[23] = mk(0, 32'h300,      1, 0, 0,             1, 0, 0,        1, 32'h300,      0, 0,        0, 32'hFFFFFFFC, 0,        0,             0);
    vecs[24] = mk(0, 32'h300,      0, 1, 32'h44440300,  0, 0, 0,        0, 0,            1, 32'h304,  1, 32'h300,      32'h304,  32'h44440300,  1);
    vecs[25] = mk(0, 32'h304,      1, 0, 0,             0, 0, 0,        1, 32'h304,      0, 0,        0, 32'h300,      32'h304,  32'h44440300,  0);
    vecs[26] = mk(1, 32'h304,      0, 0, 0,             0, 0, 0,        0, 0,            0, 0,        0, 0,            0,        0,             0);
    vecs[27] = mk(0, 0,            0, 1, 32'h55550000,  0, 0, 0,        1, 0,            0, 0,        0, 0,            0,        0,             0);
    vecs[28] = mk(0, 0,            1, 0, 0,             0, 0, 0,        1, 0,            0, 0,        0, 0,            0,        0,             0);
    vecs[29] = mk(0, 0,            0, 1, 32'h66660000,  0, 0, 0,        0, 0,            1, 4,        1, 0,            4,        32'h66660000,  1);
    vecs[30] = mk(0, 4,            1, 0, 0,             0, 0, 0,        1, 4,            0, 0,        0, 0,            4,        32'h66660000,  0);
    vecs[31] = mk(0, 4,            0, 1, 32'h77770004,  0, 1, 32'h400,  0, 0,            1, 32'h400,  0, 0,            4,        0,             0);
    vecs[32] = mk(0, 32'h400,      1, 0, 0,             0, 0, 0,        1, 32'h400,      0, 0,        0, 0,            4,        0,             0);

    for (int i = 0; i < NV; i++) begin
      logic [31:0] expF, expS;
      applyStimulus(vecs[i]);
      if (!vecs[i].rst && vecs[i].gnt && vecs[i].req) gntPc = vecs[i].pc;
      if (vecs[i].push) sbQ.push_back({gntPc, vecs[i].rdata});

      @(negedge clk);
      checkOutput($sformatf("v%0d.imemReq", i), 32'(imem_req), 32'(vecs[i].req));
      checkOutput($sformatf("v%0d.imemAddr", i), imem_addr, vecs[i].addr);
      checkOutput($sformatf("v%0d.pcWrite", i), 32'(pc_write), 32'(vecs[i].pw));
      checkOutput($sformatf("v%0d.pcNext", i), pc_next, vecs[i].pn);

      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.ifidValid", i), 32'(ifid_valid), 32'(vecs[i].vld));
      checkOutput($sformatf("v%0d.ifidPc", i), ifid_pc, vecs[i].ipc);
      checkOutput($sformatf("v%0d.ifidPc4", i), ifid_pc4, vecs[i].ipc4);
      checkOutput($sformatf("v%0d.ifidInstr", i), ifid_instr, vecs[i].instr);

      if (vecs[i].rst) begin
        modelFetched = 0;
        modelStall   = 0;
      end else begin
        if (vecs[i].stl) modelStall++;
        if (!vecs[i].stl && !vecs[i].redir && vecs[i].vld) modelFetched++;
      end
`ifdef FETCH_PERF_CNT_EN
      expF = modelFetched;
      expS = modelStall;
`else
      expF = 32'h0;
      expS = 32'h0;
`endif
      checkOutput($sformatf("v%0d.perfFetched", i), perf_fetched, expF);
      checkOutput($sformatf("v%0d.perfStallCyc", i), perf_stall_cyc, expS);
    end

    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
